// File: rtl/regfile_writeback_if.sv
// Producer-side handshake bundle for regfile_writeback: the ALU result channel
// and the load/store-unit result channel.
interface regfile_writeback_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            lsu_valid;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready
    );
endinterface

// File: rtl/regfile_writeback.sv
// Writeback stage owning the register-bank write port: ALU has priority, LSU results queue in an in-order FIFO.
// Optional read-port forwarding of the in-flight write is enabled by defining WB_BYPASS_EN.
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    regfile_writeback_if.slave wb,
    output logic              rf_write,
    output logic [4:0]        rf_des_reg,
    output logic [XLEN-1:0]   rf_write_data,
    output logic [31:0]       pending_mask
`ifdef WB_BYPASS_EN
    ,
    input  logic [XLEN-1:0]   rf_read_data1,
    input  logic [XLEN-1:0]   rf_read_data2,
    input  logic [4:0]        rd_src1,
    input  logic [4:0]        rd_src2,
    output logic [XLEN-1:0]   fwd_data1,
    output logic [XLEN-1:0]   fwd_data2
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {SEL_NONE, SEL_ALU, SEL_FIFO} sel_t;

    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [4:0]      fifo_rd   [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;

    logic full, alu_fire, lsu_fire, enq, deq;
    sel_t sel;

    assign full         = (count == CW'(DEPTH));
    assign wb.alu_ready = ~full;
    assign wb.lsu_ready = ~full;
    assign alu_fire     = wb.alu_valid & ~full;
    assign lsu_fire     = wb.lsu_valid & ~full;
    assign enq          = lsu_fire & (wb.lsu_rd != 5'd0);
    assign deq          = (sel == SEL_FIFO);

    // A full FIFO overrides ALU priority so that queued loads are guaranteed to drain.
    always_comb begin
        sel = SEL_NONE;
        if (full)
            sel = SEL_FIFO;
        else if (alu_fire)
            sel = SEL_ALU;
        else if (count != '0)
            sel = SEL_FIFO;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_data[wr_ptr] <= wb.lsu_data;
            fifo_rd[wr_ptr]   <= wb.lsu_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            rf_write      <= 1'b0;
            rf_des_reg    <= '0;
            rf_write_data <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + AW'(1);
            if (deq)
                rd_ptr <= rd_ptr + AW'(1);
            if (enq && !deq)
                count <= count + CW'(1);
            else if (!enq && deq)
                count <= count - CW'(1);

            case (sel)
                SEL_ALU: begin
                    rf_write      <= (wb.alu_rd != 5'd0);
                    rf_des_reg    <= wb.alu_rd;
                    rf_write_data <= wb.alu_data;
                end
                SEL_FIFO: begin
                    rf_write      <= 1'b1;
                    rf_des_reg    <= fifo_rd[rd_ptr];
                    rf_write_data <= fifo_data[rd_ptr];
                end
                default: rf_write <= 1'b0;
            endcase
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count)
                pending_mask[fifo_rd[rd_ptr + AW'(i)]] = 1'b1;
        end
        if (rf_write)
            pending_mask[rf_des_reg] = 1'b1;
        pending_mask[0] = 1'b0;
    end

`ifdef WB_BYPASS_EN
    assign fwd_data1 = (rf_write && (rf_des_reg == rd_src1) && (rd_src1 != 5'd0))
                       ? rf_write_data : rf_read_data1;
    assign fwd_data2 = (rf_write && (rf_des_reg == rd_src2) && (rd_src2 != 5'd0))
                       ? rf_write_data : rf_read_data2;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized scoreboard bench for regfile_writeback; a queue-based reference model
// predicts every committed register write, and a negedge monitor checks them in order.
module tb_regfile_writeback;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rf_write;
    logic [4:0]  rf_des_reg;
    logic [31:0] rf_write_data;
    logic [31:0] pending_mask;
`ifdef WB_BYPASS_EN
    logic [31:0] rf_read_data1, rf_read_data2, fwd_data1, fwd_data2;
    logic [4:0]  rd_src1, rd_src2;
    bit          byp_hold = 1'b0;
`endif

    regfile_writeback_if #(.XLEN(XLEN)) wb();

    regfile_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb            (wb.slave),
        .rf_write      (rf_write),
        .rf_des_reg    (rf_des_reg),
        .rf_write_data (rf_write_data),
        .pending_mask  (pending_mask)
`ifdef WB_BYPASS_EN
        ,
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .rd_src1       (rd_src1),
        .rd_src2       (rd_src2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t  lsu_q[$];
    wr_t  exp_q[$];
    logic m_out_valid = 1'b0;
    wr_t  m_out = '0;
    bit   last_af, last_lf;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (lsu_q[i]) m[lsu_q[i].rd] = 1'b1;
        if (m_out_valid) m[m_out.rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic check_state();
        check("alu_ready", 32'(wb.alu_ready), 32'(lsu_q.size() < DEPTH));
        check("lsu_ready", 32'(wb.lsu_ready), 32'(lsu_q.size() < DEPTH));
        check("rf_write", 32'(rf_write), 32'(m_out_valid));
        check("pending_mask", pending_mask, model_mask());
`ifdef WB_BYPASS_EN
        check("fwd_data1", fwd_data1,
              (m_out_valid && m_out.rd == rd_src1 && rd_src1 != 5'd0) ? m_out.data : rf_read_data1);
        check("fwd_data2", fwd_data2,
              (m_out_valid && m_out.rd == rd_src2 && rd_src2 != 5'd0) ? m_out.data : rf_read_data2);
`endif
    endtask

    task automatic settle();
`ifdef WB_BYPASS_EN
        if (!byp_hold) begin
            rd_src1       = 5'($urandom_range(0, 31));
            rd_src2       = 5'($urandom_range(0, 31));
            rf_read_data1 = $urandom;
            rf_read_data2 = $urandom;
        end
`endif
        #1;
    endtask

    // One clock: check current state, drive inputs, advance the model by one edge.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        bit full;
        check_state();
        wb.alu_valid = av; wb.alu_rd = ar; wb.alu_data = ad;
        wb.lsu_valid = lv; wb.lsu_rd = lr; wb.lsu_data = ld;
        full    = (lsu_q.size() == DEPTH);
        last_af = av && !full;
        last_lf = lv && !full;
        if (full) begin
            m_out = lsu_q.pop_front(); m_out_valid = 1'b1;
        end else if (last_af) begin
            m_out = '{rd: ar, data: ad}; m_out_valid = (ar != 5'd0);
        end else if (lsu_q.size() > 0) begin
            m_out = lsu_q.pop_front(); m_out_valid = 1'b1;
        end else begin
            m_out_valid = 1'b0;
        end
        if (m_out_valid) exp_q.push_back(m_out);
        if (last_lf && lr != 5'd0) lsu_q.push_back('{rd: lr, data: ld});
        @(posedge clk); #1;
        settle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd9;  wb.alu_data = $urandom;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd17; wb.lsu_data = $urandom;
        @(posedge clk); #1;
        reset = 1'b0;
        wb.alu_valid = 1'b0; wb.lsu_valid = 1'b0;
        check("reset_drained", 32'(exp_q.size()), 32'd0);
        lsu_q.delete(); exp_q.delete(); m_out_valid = 1'b0;
        settle();
    endtask

    // Monitor: every write the DUT presents must be the next predicted write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rf_write === 1'b1) begin
                check("wr_nonzero_rd", 32'(rf_des_reg == 5'd0), 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got rd %0d data %h, expected no write", rf_des_reg, rf_write_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_rd", 32'(rf_des_reg), 32'(e.rd));
                    check("wr_data", rf_write_data, e.data);
                end
            end
        end
    end

    initial begin
        logic [4:0] ar, lr;
        reset = 1'b1;
        wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
        wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_data = '0;
`ifdef WB_BYPASS_EN
        rd_src1 = '0; rd_src2 = '0; rf_read_data1 = '0; rf_read_data2 = '0;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_rf_write", 32'(rf_write), 32'd0);
        check("reset_rf_des_reg", 32'(rf_des_reg), 32'd0);
        check("reset_rf_write_data", rf_write_data, 32'd0);
        check("reset_pending_mask", pending_mask, 32'd0);
        check("reset_alu_ready", 32'(wb.alu_ready), 32'd1);
        check("reset_lsu_ready", 32'(wb.lsu_ready), 32'd1);
        settle();

        // Single ALU write
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check("t1_rd", 32'(rf_des_reg), 32'd5);
        check("t1_data", rf_write_data, 32'hDEADBEEF);
        check("t1_mask", pending_mask, 32'h20);
        idle(1);
        check("t1_mask_clear", pending_mask, 32'd0);

        // x0 suppression on both producers
        step(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678);
        check("x0_rf_write", 32'(rf_write), 32'd0);
        check("x0_mask", pending_mask, 32'd0);
        check("x0_lsu_ready", 32'(wb.lsu_ready), 32'd1);
        idle(2);

        // ALU priority fills the FIFO, then the full FIFO stalls the ALU
        ar = 5'd1; lr = 5'd10;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, ar, $urandom, (lr <= 5'd13), lr, $urandom);
            if (last_af) ar = ar + 5'd1;
            if (last_lf && lr <= 5'd13) lr = lr + 5'd1;
            if (i == 3) check("fill_lsu_ready", 32'(wb.lsu_ready), 32'd0);
        end
        idle(6);

        // Wrap-around: ten loads, no ALU traffic
        for (int k = 1; k <= 10; k++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(k), 32'(k) * 32'h11);
        idle(3);

        // Reset with entries queued and a write in the output stage
        for (int k = 0; k < 3; k++)
            step(1'b1, 5'(20 + k), $urandom, 1'b1, 5'(24 + k), $urandom);
        step(1'b1, 5'd30, $urandom, 1'b0, 5'd0, 32'd0);
        check("pre_reset_rf_write", 32'(rf_write), 32'd1);
        do_reset();
        check("post_reset_rf_write", 32'(rf_write), 32'd0);
        check("post_reset_mask", pending_mask, 32'd0);
        check("post_reset_lsu_ready", 32'(wb.lsu_ready), 32'd1);
        idle(8);

`ifdef WB_BYPASS_EN
        step(1'b1, 5'd7, 32'hCAFE0007, 1'b0, 5'd0, 32'd0);
        byp_hold = 1'b1;
        rd_src1 = 5'd7; rd_src2 = 5'd0; rf_read_data1 = 32'h0; rf_read_data2 = 32'h99;
        #1;
        check("byp_fwd1", fwd_data1, 32'hCAFE0007);
        check("byp_fwd2", fwd_data2, 32'h99);
        byp_hold = 1'b0;
        idle(2);
`endif

        // Randomized traffic with one mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom);
        end
        idle(10);
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
